// File: rtl/rr_axil_multichan_recorder.sv
// Multi-channel valid/ready recorder: per-channel FIFOs plus one packed event record register.
// Optional statistics counters are built only when RR_RECORDER_STATS_EN is defined.

module rr_axil_recorder_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
endmodule

module rr_axil_multichan_recorder #(
    parameter int                NUM_CH     = 5,
    parameter int                DATA_W     = 64,
    parameter logic [NUM_CH-1:0] LOGB_MASK  = 5'b00111,
    parameter int                PIPE_DEPTH = 4,
    parameter int                CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     record_en,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [NUM_CH-1:0]        log_logb_valid,
    output logic [NUM_CH-1:0]        log_loge_valid,
    output logic [NUM_CH*DATA_W-1:0] log_data,
    output logic [CNT_W-1:0]         stat_rec_cnt,
    output logic [CNT_W-1:0]         stat_stall_cnt
);
    logic                     log_valid_q;
    logic [NUM_CH-1:0]        logb_q, loge_q;
    logic [NUM_CH*DATA_W-1:0] ldata_q, ldata_d;
    logic [NUM_CH-1:0]        full, empty, push, pop, logb_ev, loge_ev;
    logic                     log_ok, gate, any_ev;

    assign log_ok = !log_valid_q || log_ready;
    // While recording, every channel freezes if the record register cannot accept a new event.
    assign gate   = !record_en || log_ok;

    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    assign logb_ev = record_en ? (push & LOGB_MASK) : '0;
    assign loge_ev = record_en ? pop : '0;
    assign any_ev  = |{logb_ev, loge_ev};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rr_axil_recorder_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (PIPE_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (in_data[g*DATA_W +: DATA_W]),
            .data_o  (out_data[g*DATA_W +: DATA_W]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );

        assign in_ready[g]  = !full[g] && gate;
        assign out_valid[g] = !empty[g] && gate;
        assign ldata_d[g*DATA_W +: DATA_W] = logb_ev[g] ? in_data[g*DATA_W +: DATA_W] : '0;
    end

    // Events only occur when log_ok, so loading never overwrites an unconsumed record.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            log_valid_q <= 1'b0;
            logb_q      <= '0;
            loge_q      <= '0;
            ldata_q     <= '0;
        end else if (any_ev) begin
            log_valid_q <= 1'b1;
            logb_q      <= logb_ev;
            loge_q      <= loge_ev;
            ldata_q     <= ldata_d;
        end else if (log_ready) begin
            log_valid_q <= 1'b0;
            logb_q      <= '0;
            loge_q      <= '0;
            ldata_q     <= '0;
        end
    end

    assign log_valid      = log_valid_q;
    assign log_logb_valid = logb_q;
    assign log_loge_valid = loge_q;
    assign log_data       = ldata_q;

`ifdef RR_RECORDER_STATS_EN
    logic [CNT_W-1:0] rec_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rec_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (log_valid_q && log_ready && !(&rec_cnt_q))
                rec_cnt_q <= rec_cnt_q + CNT_W'(1);
            if (record_en && log_valid_q && !log_ready && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stat_rec_cnt   = rec_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_rec_cnt   = '0;
    assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_axil_multichan_recorder.sv
// Directed bench for rr_axil_multichan_recorder: vector table plus hand-written corner sequences.

module tb_rr_axil_multichan_recorder;
    localparam int NC = 5;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic              record_en;
    logic [NC-1:0]     in_valid, in_ready, out_valid, out_ready;
    logic [NC*DW-1:0]  in_data, out_data, log_data;
    logic              log_valid, log_ready;
    logic [NC-1:0]     log_logb_valid, log_loge_valid;
    logic [31:0]       stat_rec_cnt, stat_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_axil_multichan_recorder dut (
        .clk            (clk),
        .rstn           (rstn),
        .record_en      (record_en),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .log_valid      (log_valid),
        .log_ready      (log_ready),
        .log_logb_valid (log_logb_valid),
        .log_loge_valid (log_loge_valid),
        .log_data       (log_data),
        .stat_rec_cnt   (stat_rec_cnt),
        .stat_stall_cnt (stat_stall_cnt)
    );

    typedef struct {
        logic          rec;
        logic [NC-1:0] iv;
        logic [15:0]   d;
        logic [NC-1:0] ordy;
        logic          lrdy;
        logic [NC-1:0] e_ir;
        logic [NC-1:0] e_ov;
        logic          e_lv;
        logic [NC-1:0] e_lb;
        logic [NC-1:0] e_le;
        int            och;
        logic [15:0]   e_od;
        logic [15:0]   e_ld0;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(logic rec, logic [NC-1:0] iv, logic [15:0] d, logic [NC-1:0] ordy,
                                logic lrdy, logic [NC-1:0] ir, logic [NC-1:0] ov, logic lv,
                                logic [NC-1:0] lb, logic [NC-1:0] le, int och, logic [15:0] od,
                                logic [15:0] ld0);
        vec_t v;
        v.rec = rec; v.iv = iv; v.d = d; v.ordy = ordy; v.lrdy = lrdy;
        v.e_ir = ir; v.e_ov = ov; v.e_lv = lv; v.e_lb = lb; v.e_le = le;
        v.och = och; v.e_od = od; v.e_ld0 = ld0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rec, input logic [NC-1:0] iv, input logic [63:0] d,
                         input logic [NC-1:0] ordy, input logic lrdy);
        record_en = rec;
        in_valid  = iv;
        out_ready = ordy;
        log_ready = lrdy;
        for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pass-through scoreboard: per-channel circular model of the buffer.
    logic [63:0] mbuf [NC][4];
    int          mrd  [NC];
    int          mcnt [NC];

    initial begin
        // v(rec, in_valid, data, out_ready, log_ready | in_ready, out_valid, log_valid, logb, loge, och, out_data[och], log slot0)
        vt[0]  = mk(1, 5'b00001, 16'h1234, 5'b11111, 1, 5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 0, 16'h0,  16'h0);
        vt[1]  = mk(1, 5'b00000, 16'h0,    5'b11111, 1, 5'b11111, 5'b00001, 1, 5'b00001, 5'b00000, 0, 16'h1234, 16'h1234);
        vt[2]  = mk(1, 5'b00000, 16'h0,    5'b11111, 1, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00001, 0, 16'h0,  16'h0);
        vt[3]  = mk(1, 5'b00000, 16'h0,    5'b11111, 1, 5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 0, 16'h0,  16'h0);
        vt[4]  = mk(1, 5'b01000, 16'h00A0, 5'b00000, 1, 5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 3, 16'h0,  16'h0);
        vt[5]  = mk(1, 5'b01000, 16'h00A1, 5'b00000, 1, 5'b11111, 5'b01000, 0, 5'b00000, 5'b00000, 3, 16'hA0, 16'h0);
        vt[6]  = mk(1, 5'b01000, 16'h00A2, 5'b00000, 1, 5'b11111, 5'b01000, 0, 5'b00000, 5'b00000, 3, 16'hA0, 16'h0);
        vt[7]  = mk(1, 5'b01000, 16'h00A3, 5'b00000, 1, 5'b11111, 5'b01000, 0, 5'b00000, 5'b00000, 3, 16'hA0, 16'h0);
        vt[8]  = mk(1, 5'b01000, 16'h00A4, 5'b00000, 1, 5'b10111, 5'b01000, 0, 5'b00000, 5'b00000, 3, 16'hA0, 16'h0);
        vt[9]  = mk(1, 5'b01000, 16'h00A4, 5'b01000, 1, 5'b10111, 5'b01000, 0, 5'b00000, 5'b00000, 3, 16'hA0, 16'h0);
        vt[10] = mk(1, 5'b01000, 16'h00A4, 5'b01000, 1, 5'b11111, 5'b01000, 1, 5'b00000, 5'b01000, 3, 16'hA1, 16'h0);
        vt[11] = mk(1, 5'b00000, 16'h0,    5'b01000, 1, 5'b11111, 5'b01000, 1, 5'b00000, 5'b01000, 3, 16'hA2, 16'h0);
        vt[12] = mk(1, 5'b00000, 16'h0,    5'b01000, 1, 5'b11111, 5'b01000, 1, 5'b00000, 5'b01000, 3, 16'hA3, 16'h0);
        vt[13] = mk(1, 5'b00000, 16'h0,    5'b01000, 1, 5'b11111, 5'b01000, 1, 5'b00000, 5'b01000, 3, 16'hA4, 16'h0);
        vt[14] = mk(1, 5'b00000, 16'h0,    5'b00000, 1, 5'b11111, 5'b00000, 1, 5'b00000, 5'b01000, 3, 16'h0,  16'h0);
        vt[15] = mk(1, 5'b00000, 16'h0,    5'b00000, 1, 5'b11111, 5'b00000, 0, 5'b00000, 5'b00000, 3, 16'h0,  16'h0);

        rstn = 1'b0;
        drive(0, '0, '0, '0, 1);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_log_valid", 64'(log_valid), 64'h0);
        chk("rst_logb", 64'(log_logb_valid), 64'h0);
        chk("rst_loge", 64'(log_loge_valid), 64'h0);
        chk("rst_log_data", 64'(|log_data), 64'h0);
        chk("rst_stat_rec", 64'(stat_rec_cnt), 64'h0);
        chk("rst_stat_stall", 64'(stat_stall_cnt), 64'h0);
        #9 rstn = 1'b1;
        next_cycle();

        for (int k = 0; k < 16; k++) begin
            drive(vt[k].rec, vt[k].iv, 64'(vt[k].d), vt[k].ordy, vt[k].lrdy);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", k), 64'(in_ready), 64'(vt[k].e_ir));
            chk($sformatf("v%0d_out_valid", k), 64'(out_valid), 64'(vt[k].e_ov));
            chk($sformatf("v%0d_log_valid", k), 64'(log_valid), 64'(vt[k].e_lv));
            chk($sformatf("v%0d_logb", k), 64'(log_logb_valid), 64'(vt[k].e_lb));
            chk($sformatf("v%0d_loge", k), 64'(log_loge_valid), 64'(vt[k].e_le));
            chk($sformatf("v%0d_log_slot0", k), log_data[0 +: DW], 64'(vt[k].e_ld0));
            chk($sformatf("v%0d_log_unmasked", k), 64'(|log_data[3*DW +: 2*DW]), 64'h0);
            if (vt[k].e_ov[vt[k].och])
                chk($sformatf("v%0d_out_data", k), out_data[vt[k].och*DW +: DW], 64'(vt[k].e_od));
            next_cycle();
        end

        // Stall: pending record with log_ready low freezes all channels.
        drive(1, 5'b00001, 64'h77, 5'b00000, 0);
        @(negedge clk);
        chk("stall_first_push_ready", 64'(in_ready), 64'h1f);
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            drive(1, 5'b11111, 64'h88, 5'b11111, 0);
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'h0);
            chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'h0);
            chk($sformatf("stall%0d_log_valid", k), 64'(log_valid), 64'h1);
            chk($sformatf("stall%0d_logb", k), 64'(log_logb_valid), 64'h1);
            chk($sformatf("stall%0d_slot0", k), log_data[0 +: DW], 64'h77);
            next_cycle();
        end
        drive(1, 5'b00000, 64'h0, 5'b00001, 1);
        @(negedge clk);
`ifdef RR_RECORDER_STATS_EN
        chk("stall_cnt", 64'(stat_stall_cnt), 64'd10);
`else
        chk("stall_cnt", 64'(stat_stall_cnt), 64'd0);
`endif
        chk("release_out_valid", 64'(out_valid), 64'h1);
        chk("release_out_data", out_data[0 +: DW], 64'h77);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 1);
        @(negedge clk);
        chk("release_loge", 64'(log_loge_valid), 64'h1);
        chk("release_log_valid", 64'(log_valid), 64'h1);
        next_cycle();
        @(negedge clk);
        chk("release_idle_log_valid", 64'(log_valid), 64'h0);
        next_cycle();

        // Same-cycle push and pop on ch1 with two entries buffered.
        drive(1, 5'b00010, 64'hC1, 5'b00000, 1);
        next_cycle();
        drive(1, 5'b00010, 64'hC2, 5'b00000, 1);
        next_cycle();
        drive(1, 5'b00010, 64'hC3, 5'b00010, 1);
        @(negedge clk);
        chk("pp_out_valid1", 64'(out_valid[1]), 64'h1);
        chk("pp_head_c1", out_data[1*DW +: DW], 64'hC1);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 1);
        @(negedge clk);
        chk("pp_logb", 64'(log_logb_valid), 64'h02);
        chk("pp_loge", 64'(log_loge_valid), 64'h02);
        chk("pp_slot1", log_data[1*DW +: DW], 64'hC3);
        chk("pp_head_c2", out_data[1*DW +: DW], 64'hC2);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00010, 1);
        @(negedge clk);
        chk("pp_drain_c2", out_data[1*DW +: DW], 64'hC2);
        next_cycle();
        @(negedge clk);
        chk("pp_drain_c3", out_data[1*DW +: DW], 64'hC3);
        chk("pp_drain_c3_valid", 64'(out_valid[1]), 64'h1);
        next_cycle();
        @(negedge clk);
        chk("pp_drain_empty", 64'(out_valid[1]), 64'h0);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 1);
        next_cycle();

        // Pass-through with random traffic against a scoreboard.
        for (int i = 0; i < NC; i++) begin
            mrd[i] = 0;
            mcnt[i] = 0;
        end
        for (int c = 0; c < 90; c++) begin
            record_en = 1'b0;
            log_ready = 1'b1;
            if (c < 80) begin
                in_valid  = NC'($urandom);
                out_ready = NC'($urandom);
                for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
            end else begin
                in_valid  = '0;
                out_ready = '1;
            end
            @(negedge clk);
            chk($sformatf("pt%0d_log_valid", c), 64'(log_valid), 64'h0);
            for (int i = 0; i < NC; i++) begin
                int  cnt0;
                cnt0 = mcnt[i];
                chk($sformatf("pt%0d_ch%0d_in_ready", c, i), 64'(in_ready[i]), 64'(cnt0 < 4));
                chk($sformatf("pt%0d_ch%0d_out_valid", c, i), 64'(out_valid[i]), 64'(cnt0 > 0));
                if (cnt0 > 0)
                    chk($sformatf("pt%0d_ch%0d_data", c, i), out_data[i*DW +: DW], mbuf[i][mrd[i]]);
                if (cnt0 > 0 && out_ready[i]) begin
                    mrd[i] = (mrd[i] + 1) % 4;
                    mcnt[i]--;
                end
                if (in_valid[i] && cnt0 < 4) begin
                    mbuf[i][(mrd[i] + mcnt[i]) % 4] = in_data[i*DW +: DW];
                    mcnt[i]++;
                end
            end
            next_cycle();
        end

        // record_en rises mid-stream: the next handshake is logged.
        drive(1, 5'b00001, 64'h55, 5'b00000, 1);
        @(negedge clk);
        chk("en_before_log_valid", 64'(log_valid), 64'h0);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 1);
        @(negedge clk);
        chk("en_log_valid", 64'(log_valid), 64'h1);
        chk("en_logb", 64'(log_logb_valid), 64'h1);
        chk("en_slot0", log_data[0 +: DW], 64'h55);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00001, 1);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 1);
        next_cycle();

        // Asynchronous reset with buffered data and a pending record.
        drive(1, 5'b00100, 64'hE0, 5'b00000, 1);
        next_cycle();
        drive(1, 5'b00100, 64'hE1, 5'b00000, 1);
        next_cycle();
        drive(1, 5'b00100, 64'hE2, 5'b00000, 1);
        next_cycle();
        drive(1, 5'b00000, 64'h0, 5'b00000, 0);
        @(negedge clk);
        chk("ar_pre_log_valid", 64'(log_valid), 64'h1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_log_valid", 64'(log_valid), 64'h0);
        chk("ar_logb", 64'(log_logb_valid), 64'h0);
        chk("ar_log_data", 64'(|log_data), 64'h0);
        chk("ar_out_valid", 64'(out_valid), 64'h0);
        log_ready = 1'b1;
        #3 rstn = 1'b1;
        @(negedge clk);
        chk("ar_post_out_valid", 64'(out_valid), 64'h0);
        chk("ar_post_in_ready", 64'(in_ready), 64'h1f);
        chk("ar_post_log_valid", 64'(log_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
